vc_vr_fifo_ctrl: RTL
====================

# vc_vr_fifo_ctrl

Flow controller for the valid/credit to valid/ready converter. It sequences one external `fifo` instance (WIDTH/DEPTH matched, asynchronous read), translating a valid/credit upstream into a valid/ready downstream. The block returns one credit per freed entry, issues the initial DEPTH credits after reset, tracks occupancy, supports a drain-flush and latches overflow as a fatal error.

## Interface
- `WIDTH`, 8: data width in bits.
- `DEPTH`, 10: fifo entries, which is also the upstream credit pool. Range 2 or more.
- `CNT_W`, derived as $clog2(DEPTH+1): width of the counters.

Ports (reset is synchronous and active-high; the polarity and synchronicity are fixed):
- `clk_i`  in  1  single clock; all logic is on its rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `up_valid_i`  in  1  upstream data valid. Legal only when the sender holds a credit.
- `up_data_i`  in  WIDTH  upstream data.
- `up_credit_o`  out  1  registered. One pulse returns one credit.
- `down_valid_o`  out  1  downstream valid.
- `down_data_o`  out  WIDTH  downstream data, equal to `fifo_data_i`.
- `down_ready_i`  in  1  downstream ready.
- `fifo_push_o`  out  1  fifo push.
- `fifo_data_o`  out  WIDTH  fifo write data, equal to `up_data_i`.
- `fifo_pop_o`  out  1  fifo pop.
- `fifo_data_i`  in  WIDTH  fifo head data.
- `fifo_empty_i`  in  1  fifo empty flag.
- `fifo_full_i`  in  1  fifo full flag.
- `flush_i`  in  1  level request to drain the fifo.
- `occupancy_o`  out  CNT_W  registered count of entries held.
- `overflow_o`  out  1  registered, sticky error flag.

## Operation
- **States:** RUN, FLUSH, ERROR. Reset state is RUN.
- **Credit counter `owed`:**
  - Reset value is DEPTH, which produces the initial credit burst.
  - `up_credit_o` is registered from (`owed` != 0) and issues at most one credit per cycle.
  - `owed` is incremented by each `fifo_pop_o` and decremented by each issued credit. A pop and a credit in the same cycle leave it unchanged.
  - `owed` never exceeds DEPTH. Invariant: `occupancy` + `owed` + credits held upstream = DEPTH.
- **Push:** `fifo_push_o` = `up_valid_i` & ~`fifo_full_i` & (state != ERROR). Push is accepted in RUN and FLUSH.
- **Overflow:**
  - Trigger is `up_valid_i` & `fifo_full_i`, even if a pop occurs in the same cycle.
  - Effect: the write is blocked, `overflow_o` is set on the next cycle, and the state goes to ERROR.
- **RUN:**
  - `down_valid_o` = ~`fifo_empty_i`.
  - `fifo_pop_o` = `down_valid_o` & `down_ready_i`.
  - If `flush_i` is high, the next state is FLUSH.
- **FLUSH:**
  - `down_valid_o` = 0.
  - `fifo_pop_o` = ~`fifo_empty_i`, which discards one entry per cycle. Credits are still returned.
  - The next state is RUN when `fifo_empty_i` is high and `flush_i` is low.
- **ERROR:**
  - `down_valid_o` = 0, `fifo_push_o` = 0, `fifo_pop_o` = 0, `up_credit_o` = 0.
  - The state holds until `rst_i`.
- **Occupancy:** `occupancy_o` is incremented on push and decremented on pop, and is unchanged on a simultaneous push and pop. It must equal the fifo content. It never exceeds DEPTH and never goes below 0.
- **Reset priority:** `rst_i` overrides every other input.

## Timing
- **Reset values:** `up_credit_o` = 0, `occupancy_o` = 0, `overflow_o` = 0, state = RUN, `owed` = DEPTH. While `fifo_empty_i` is high, `down_valid_o` = 0 and `fifo_push_o` = `fifo_pop_o` = 0.
- **Initial burst:** `up_credit_o` is high for DEPTH consecutive cycles, starting in the first cycle after `rst_i` is released, when no pops occur.
- **Data latency:** a push in cycle t makes `down_valid_o` high in cycle t+1, from the fifo's registered pointers. There is no bubble on back-to-back transfers.
- **Credit latency:** a pop in cycle t produces `up_credit_o` in cycle t+1 if `owed` was 0, otherwise it is queued behind the pending credits.
- **Combinational paths:** push, pop, `down_valid_o` and both data buses are combinational from their inputs. All other outputs are registered.
- **State change timing:** a FLUSH entry or exit, or an ERROR entry, takes effect in the cycle after the condition.
- **Mid-operation reset:** reset during any state returns to the reset values on the next edge. Fifo contents are ignored because the fifo is reset alongside the controller.

## Test plan
- **Reset burst:** release `rst_i`, hold `up_valid_i` = 0 -> exactly DEPTH (10) `up_credit_o` pulses on cycles 1..10, then 0; `occupancy_o` = 0.
- **Streaming:** with `down_ready_i` = 1, send 20 words 0x00..0x13, one per credit -> they appear in order with 1-cycle latency; credits keep pace; `overflow_o` = 0.
- **Backpressure:** with `down_ready_i` = 0, send 10 words -> `occupancy_o` = 10, `fifo_full_i` high, no credits after the burst. Then ready = 1 for 3 cycles -> 3 pops, 3 credits, `occupancy_o` = 7.
- **Overflow:** with the fifo full, force `up_valid_i` = 1 -> no push, `overflow_o` = 1 the next cycle, and all outputs quiet. `overflow_o` holds until `rst_i`, which clears it.
- **Flush:** with 6 entries held, pulse `flush_i` for 1 cycle -> 6 discarding pops with `down_valid_o` = 0, 6 credits returned, `occupancy_o` = 0, return to RUN.
- **Mid-operation reset:** assert `rst_i` mid-transfer with `occupancy_o` = 4 -> the next cycle shows reset values and a fresh 10-credit burst.

Source files
------------

// File: rtl/vc_vr_fifo_ctrl.sv
// Flow controller that bridges a valid/credit upstream to a valid/ready downstream
// around an external asynchronous-read fifo. It owns credit return, occupancy, drain-flush and overflow.
module vc_vr_fifo_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 10,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  output logic             up_credit_o,
  output logic             down_valid_o,
  output logic [WIDTH-1:0] down_data_o,
  input  logic             down_ready_i,
  output logic             fifo_push_o,
  output logic [WIDTH-1:0] fifo_data_o,
  output logic             fifo_pop_o,
  input  logic [WIDTH-1:0] fifo_data_i,
  input  logic             fifo_empty_i,
  input  logic             fifo_full_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] occupancy_o,
  output logic             overflow_o
);

  typedef enum logic [1:0] {RUN, FLUSH, ERROR} state_t;

  state_t           state;
  logic [CNT_W-1:0] owed;
  logic             ovf_trig;
  logic             issue;

  assign fifo_data_o = up_data_i;
  assign down_data_o = fifo_data_i;

  always_comb begin
    fifo_push_o  = up_valid_i & ~fifo_full_i & (state != ERROR);
    ovf_trig     = up_valid_i & fifo_full_i & (state != ERROR);
    down_valid_o = 1'b0;
    fifo_pop_o   = 1'b0;
    case (state)
      RUN: begin
        down_valid_o = ~fifo_empty_i;
        fifo_pop_o   = ~fifo_empty_i & down_ready_i;
      end
      FLUSH:   fifo_pop_o = ~fifo_empty_i;
      default: ;
    endcase
    // A pop with nothing owed is returned straight away so the credit appears the next cycle.
    issue = (state != ERROR) & ~ovf_trig & ((owed != '0) | fifo_pop_o);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= RUN;
      owed        <= CNT_W'(DEPTH);
      up_credit_o <= 1'b0;
      occupancy_o <= '0;
      overflow_o  <= 1'b0;
    end else begin
      up_credit_o <= issue;

      if (fifo_pop_o && !issue)
        owed <= owed + CNT_W'(1);
      else if (!fifo_pop_o && issue)
        owed <= owed - CNT_W'(1);

      if (fifo_push_o && !fifo_pop_o)
        occupancy_o <= occupancy_o + CNT_W'(1);
      else if (!fifo_push_o && fifo_pop_o)
        occupancy_o <= occupancy_o - CNT_W'(1);

      if (ovf_trig)
        overflow_o <= 1'b1;

      case (state)
        RUN: begin
          if (ovf_trig)     state <= ERROR;
          else if (flush_i) state <= FLUSH;
        end
        FLUSH: begin
          if (ovf_trig)                       state <= ERROR;
          else if (fifo_empty_i && !flush_i)  state <= RUN;
        end
        default: state <= ERROR;
      endcase
    end
  end

endmodule
